aes128_line_packer: RTL and testbench
=====================================

# aes128_line_packer

Buffering stage directly downstream of the `aes128` core and upstream of the `aes128_requestor` write path. It collects 128-bit cipher blocks emitted by `aes128` (`valid_out`/`data_out`, no backpressure), packs four consecutive blocks into one 512-bit CCI-P cache line, and queues lines in a FIFO. The requestor drains the FIFO with a ready/valid handshake, and `almost_full` tells it to stop issuing reads. A fixed-latency AES pipeline can never be stalled, so the buffer must absorb every block already in flight.

## Interface
Parameters:
- `DEPTH`, 16: FIFO capacity in lines; power of two, at least 4.
- `AFULL_SLACK`, 4: lines of headroom reserved for blocks in flight when `almost_full` asserts.

Ports:
- `clk`, in, 1: single clock (`pClkDiv2` domain).
- `reset_n`, in, 1: synchronous, active-low reset.
- `data_in`, in, 128: cipher block from `aes128.data_out`.
- `valid_in`, in, 1: block strobe from `aes128.valid_out`.
- `flush`, in, 1: one-cycle pulse that pushes any partial line.
- `line_out`, out, 512: head-of-FIFO line; block k is at bits `[128*k +: 128]`.
- `line_blocks`, out, 3: number of valid blocks in `line_out`, 1–4.
- `line_valid`, out, 1: FIFO not empty.
- `line_ready`, in, 1: requestor accepts the head line.
- `almost_full`, out, 1: stop issuing new AES work.
- `occupancy`, out, $clog2(DEPTH+1): lines stored.
- `overflow_err`, out, 1: sticky flag; a line was dropped.

## Operation
- **Packing.** A 2-bit lane counter `lane` and a 4×128 pack register.
  - On `valid_in`, write `data_in` to lane `lane` and increment `lane`.
  - When `lane==3` and `valid_in`, push the full line with `line_blocks=4` and wrap `lane` to 0.
- **Flush.**
  - `flush` with `lane>0` and no `valid_in`: push the partial line with unused lanes zeroed, `line_blocks=lane`, and set `lane` to 0.
  - `flush` together with `valid_in`: the block is packed first. If that completes the line, exactly one full line is pushed. Otherwise the partial line (`lane+1` blocks) is pushed.
  - `flush` with `lane==0` and no `valid_in`: no-op.
- **Pop.** Occurs when `line_valid && line_ready`.
- **Push.** Succeeds when `occupancy<DEPTH` or when a pop happens in the same cycle.
  - Push into a full FIFO with no pop: the line is dropped, `overflow_err` sets, and the `lane` counter still resets.
- **Occupancy.** `occupancy` changes by +1, −1, or 0 when push and pop happen together. It never exceeds `DEPTH` and never wraps below 0.
- **Almost full.** `almost_full = (occupancy >= DEPTH-AFULL_SLACK)`, registered from the next-state count.
- **Empty FIFO.** When `line_valid=0`, `line_ready` is ignored and `line_out` holds its last value.
- **Reset.** Reset mid-operation discards the partial line and all queued lines.

## Timing
- Reset values (`reset_n=0` sampled at an edge): `lane=0`, pack register 0, `line_valid=0`, `line_out=0`, `line_blocks=0`, `occupancy=0`, `almost_full=0`, `overflow_err=0`.
- Push latency: a line completed at edge t shows `line_valid=1`, with its data on `line_out`, after edge t+1 when the FIFO was empty. This is show-ahead behaviour with a registered head.
- Pop: the next line appears the cycle after the accepting edge. Back-to-back pops sustain 1 line per cycle.
- Throughput: 1 block per cycle in, 1 line per 4 cycles pushed. No bubbles are inserted on the input.
- `almost_full` and `occupancy` update one cycle after the causing push or pop.

## Structure
- Additions to `aes128_pkg`:
  - `AES_BLOCK_BITS=128`, `CL_BITS=512`, `BLOCKS_PER_LINE=4`.
  - `typedef logic [CL_BITS-1:0] t_aes_line`.
  - `typedef struct packed { t_aes_line data; logic [2:0] blocks; } t_aes_line_entry`.
- Sub-module `aes128_line_fifo`: a generic synchronous FIFO of `t_aes_line_entry` with a registered show-ahead head, plus count, push, pop and full/empty.
- The packer logic (lane counter, flush, overflow) stays in `aes128_line_packer`.

## Test plan
- **Basic packing.** Send 8 consecutive blocks `0x…01`–`0x…08`. Expect two lines: the first has bits `[127:0]=0x…01` and `[511:384]=0x…04`, `line_blocks=4`. `line_valid` rises one cycle after the 4th block.
- **Partial flush.** Send 2 blocks, then `flush`. Expect one line with `line_blocks=2` and upper 256 bits zero. Then send 4 more blocks and expect a full line aligned at lane 0.
- **Flush on the completing beat.** Assert `flush` on the same cycle as a 4th `valid_in`. Expect exactly one line with `line_blocks=4` and no empty line.
- **Threshold and overflow.** Hold `line_ready=0` with `DEPTH=16`, `AFULL_SLACK=4`.
  - `almost_full` rises when `occupancy` reaches 12.
  - The 17th line is dropped, `overflow_err=1` and stays sticky, and `occupancy` remains 16.
- **Simultaneous push and pop at full.** At `occupancy=16`, assert `line_ready` on the same edge a line completes. No drop occurs, `occupancy` stays 16, and lines exit in order.
- **Reset mid-operation.** With 3 lines queued and `lane=2`, pulse `reset_n=0` for one edge. All outputs return to 0, and the next 4 blocks form one line starting at lane 0.

Source files
------------

// File: rtl/aes128_pkg.sv
// Shared types for the AES-128 datapath: cipher block, CCI-P cache line, and
// the packed line entry carried through the line FIFO.
package aes128_pkg;

    localparam int AES_BLOCK_BITS  = 128;
    localparam int CL_BITS         = 512;
    localparam int BLOCKS_PER_LINE = 4;

    typedef logic [AES_BLOCK_BITS-1:0] t_aes_block;
    typedef logic [CL_BITS-1:0]        t_aes_line;

    typedef struct packed {
        t_aes_line  data;
        logic [2:0] blocks;
    } t_aes_line_entry;

endpackage

// File: rtl/aes128_line_fifo.sv
// Synchronous FIFO of line entries with a registered show-ahead head, an
// occupancy count and a registered almost-full level.
module aes128_line_fifo
    import aes128_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push_i,
    input  t_aes_line_entry            push_data_i,
    input  logic                       pop_i,
    output t_aes_line_entry            head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       afull_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    t_aes_line_entry mem_q [DEPTH];
    t_aes_line_entry head_q, head_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q;
    logic [CW-1:0]   count_q, count_d, remain;
    logic            afull_q;
    logic            pop, push_ok;

    assign pop     = pop_i && (count_q != '0);
    assign push_ok = push_i && ((count_q != CW'(DEPTH)) || pop);
    assign remain  = count_q - CW'(pop);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !push_ok)
            count_d = count_q - CW'(1);

        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

        // The head is registered: when the pushed entry becomes the front it
        // bypasses storage, and an emptied FIFO keeps presenting its last head.
        head_d = head_q;
        if (count_d != '0) begin
            if (push_ok && (remain == '0))
                head_d = push_data_i;
            else
                head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            afull_q  <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            if (push_ok)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            count_q  <= count_d;
            head_q   <= head_d;
            afull_q  <= (count_d >= CW'(AFULL_LEVEL));
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = head_q;
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign afull_o = afull_q;

endmodule

// File: rtl/aes128_line_packer.sv
// Packs 128-bit AES output blocks four at a time into 512-bit cache lines and
// queues them for the requestor; the AES side is never stalled.
module aes128_line_packer
    import aes128_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int AFULL_SLACK = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [AES_BLOCK_BITS-1:0]  data_in,
    input  logic                       valid_in,
    input  logic                       flush,
    output logic [CL_BITS-1:0]         line_out,
    output logic [2:0]                 line_blocks,
    output logic                       line_valid,
    input  logic                       line_ready,
    output logic                       almost_full,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       overflow_err
);

    logic [1:0]      lane_q, lane_d;
    t_aes_line       pack_q, pack_d, line_c;
    logic [2:0]      nblk;
    logic            complete, do_push;
    logic            push_q;
    t_aes_line_entry push_entry_q, head;
    logic            overflow_q;
    logic            fifo_full, fifo_empty, pop, drop;

    always_comb begin
        line_c = pack_q;
        for (int k = 0; k < BLOCKS_PER_LINE; k++) begin
            if (valid_in && (lane_q == 2'(k)))
                line_c[k*AES_BLOCK_BITS +: AES_BLOCK_BITS] = data_in;
        end

        complete = valid_in && (lane_q == 2'(BLOCKS_PER_LINE-1));
        nblk     = {1'b0, lane_q} + 3'(valid_in);
        // A flush on the completing beat folds into the full line; an empty flush does nothing.
        do_push  = complete || (flush && (nblk != 3'd0));

        lane_d = valid_in ? lane_q + 2'd1 : lane_q;
        pack_d = line_c;
        if (do_push) begin
            lane_d = 2'd0;
            pack_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lane_q       <= 2'd0;
            pack_q       <= '0;
            push_q       <= 1'b0;
            push_entry_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            lane_q       <= lane_d;
            pack_q       <= pack_d;
            push_q       <= do_push;
            push_entry_q <= '{data: line_c, blocks: nblk};
            overflow_q   <= overflow_q | drop;
        end
    end

    assign pop  = !fifo_empty && line_ready;
    assign drop = push_q && fifo_full && !pop;

    aes128_line_fifo #(
        .DEPTH       (DEPTH),
        .AFULL_LEVEL (DEPTH - AFULL_SLACK)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (push_q),
        .push_data_i (push_entry_q),
        .pop_i       (line_ready),
        .head_o      (head),
        .count_o     (occupancy),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .afull_o     (almost_full)
    );

    assign line_out     = head.data;
    assign line_blocks  = head.blocks;
    assign line_valid   = !fifo_empty;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_aes128_line_packer.sv
// Bench for aes128_line_packer: table of packing/flush bursts plus directed
// sequences for latency, threshold, overflow, push-with-pop at full and reset.
module tb_aes128_line_packer;
    import aes128_pkg::*;

    localparam int DEPTH = 16;
    localparam int SLACK = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [127:0]        data_in = '0;
    logic                valid_in = 1'b0;
    logic                flush = 1'b0;
    logic                line_ready = 1'b0;
    logic [511:0]        line_out;
    logic [2:0]          line_blocks;
    logic                line_valid;
    logic                almost_full;
    logic [CW-1:0]       occupancy;
    logic                overflow_err;

    aes128_line_packer #(.DEPTH(DEPTH), .AFULL_SLACK(SLACK)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .flush        (flush),
        .line_out     (line_out),
        .line_blocks  (line_blocks),
        .line_valid   (line_valid),
        .line_ready   (line_ready),
        .almost_full  (almost_full),
        .occupancy    (occupancy),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         nblk;
        bit         flush_last;
        bit         flush_after;
        int         exp_lines;
        logic [2:0] exp_last_blocks;
    } vec_t;

    int              checks = 0;
    int              errors = 0;
    int              pops = 0;
    logic [2:0]      last_blocks = '0;
    t_aes_line_entry sb[$];
    t_aes_line_entry exp_e;
    int              mlane = 0;
    logic [511:0]    mpack = '0;
    bit              exp_drop = 1'b0;
    int              seq = 1;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard side: every accepted pop must match the oldest expected line.
    always @(negedge clk) begin
        if (reset_n && line_valid && line_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got line %0h, expected none", line_out);
            end else begin
                exp_e = sb.pop_front();
                check("line_data", line_out, exp_e.data);
                check("line_blocks", 512'(line_blocks), 512'(exp_e.blocks));
            end
            last_blocks = line_blocks;
            pops++;
        end
    end

    task automatic drive(input logic v, input logic f);
        logic [127:0] d;
        int nb;
        d = {$urandom(), $urandom(), $urandom(), 32'(seq)};
        if (v) seq++;
        valid_in = v;
        data_in  = d;
        flush    = f;
        nb = mlane + (v ? 1 : 0);
        if (v) mpack[128*mlane +: 128] = d;
        if (nb == 4 || (f && nb > 0)) begin
            if (!exp_drop) sb.push_back('{data: mpack, blocks: 3'(nb)});
            mpack = '0;
            mlane = 0;
        end else begin
            mlane = nb;
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        line_ready = 1'b1;
        while (line_valid && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        line_ready = 1'b0;
        check("drain_done", 512'(line_valid), 512'(0));
        check("sb_empty", 512'(sb.size()), 512'(0));
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, 512'(line_valid), 512'(0));
        check({tag, "_line"}, line_out, 512'(0));
        check({tag, "_blocks"}, 512'(line_blocks), 512'(0));
        check({tag, "_occ"}, 512'(occupancy), 512'(0));
        check({tag, "_afull"}, 512'(almost_full), 512'(0));
        check({tag, "_ovf"}, 512'(overflow_err), 512'(0));
    endtask

    vec_t vecs[$];
    int   pops0;

    initial begin
        vecs.push_back('{8, 1'b0, 1'b0, 2, 3'd4});  // two full lines
        vecs.push_back('{2, 1'b0, 1'b1, 1, 3'd2});  // partial flush
        vecs.push_back('{4, 1'b0, 1'b0, 1, 3'd4});  // realigned full line
        vecs.push_back('{4, 1'b1, 1'b0, 1, 3'd4});  // flush on completing beat
        vecs.push_back('{3, 1'b1, 1'b0, 1, 3'd3});  // flush with a non-completing block
        vecs.push_back('{1, 1'b0, 1'b1, 1, 3'd1});
        vecs.push_back('{0, 1'b0, 1'b1, 0, 3'd0});  // flush with nothing packed
        vecs.push_back('{5, 1'b0, 1'b1, 2, 3'd1});
        vecs.push_back('{6, 1'b0, 1'b0, 1, 3'd4});  // leaves two blocks packed
        vecs.push_back('{2, 1'b1, 1'b0, 1, 3'd4});

        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_zero_outputs("reset");

        // Push latency and head contents
        repeat (4) drive(1'b1, 1'b0);
        check("lat_valid_early", 512'(line_valid), 512'(0));
        @(posedge clk);
        #1;
        check("lat_valid", 512'(line_valid), 512'(1));
        check("lat_blocks", 512'(line_blocks), 512'(4));
        check("lat_occ", 512'(occupancy), 512'(1));
        check("lat_lane0", 512'(line_out[127:0]), 512'(sb[0].data[127:0]));
        drain();

        foreach (vecs[i]) begin
            pops0 = pops;
            for (int b = 0; b < vecs[i].nblk; b++)
                drive(1'b1, vecs[i].flush_last && (b == vecs[i].nblk - 1));
            if (vecs[i].flush_after) drive(1'b0, 1'b1);
            idle(2);
            check("vec_occ", 512'(occupancy), 512'(vecs[i].exp_lines));
            drain();
            check("vec_lines", 512'(pops - pops0), 512'(vecs[i].exp_lines));
            if (vecs[i].exp_lines > 0)
                check("vec_last_blocks", 512'(last_blocks), 512'(vecs[i].exp_last_blocks));
        end

        // Fill to DEPTH with no drain, watching the threshold
        for (int k = 1; k <= DEPTH; k++) begin
            repeat (4) drive(1'b1, 1'b0);
            idle(1);
            check("fill_occ", 512'(occupancy), 512'(k));
            check("fill_afull", 512'(almost_full), 512'((k >= DEPTH - SLACK) ? 1 : 0));
        end

        // Full FIFO: a line arrives on the same edge as a pop
        repeat (4) drive(1'b1, 1'b0);
        line_ready = 1'b1;
        @(posedge clk);
        #1;
        line_ready = 1'b0;
        check("pushpop_occ", 512'(occupancy), 512'(DEPTH));
        check("pushpop_noovf", 512'(overflow_err), 512'(0));

        // Full FIFO without a pop: the line is lost
        exp_drop = 1'b1;
        repeat (4) drive(1'b1, 1'b0);
        idle(1);
        exp_drop = 1'b0;
        check("drop_occ", 512'(occupancy), 512'(DEPTH));
        check("drop_ovf", 512'(overflow_err), 512'(1));
        idle(2);
        check("drop_ovf_sticky", 512'(overflow_err), 512'(1));
        drain();
        check("post_drain_ovf", 512'(overflow_err), 512'(1));
        check("post_drain_occ", 512'(occupancy), 512'(0));

        // Reset with three lines queued and two blocks packed
        repeat (14) drive(1'b1, 1'b0);
        idle(1);
        check("pre_reset_occ", 512'(occupancy), 512'(3));
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        sb.delete();
        mlane = 0;
        mpack = '0;
        check_zero_outputs("midreset");
        repeat (4) drive(1'b1, 1'b0);
        idle(1);
        check("post_reset_occ", 512'(occupancy), 512'(1));
        check("post_reset_blocks", 512'(line_blocks), 512'(4));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
